led_driver: RTL and testbench



---
 rtl/led_pkg.sv | 19 +
 rtl/led_channel.sv | 68 ++++++
 rtl/led_driver.sv | 66 ++++++
 tb/tb_led_driver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared MODE encodings, brightness constant and PWM compare helper for the
// LED output path.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'b00,
    MODE_STRETCH = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_OFF     = 2'b11
  } mode_e;

  localparam logic [3:0] BRIGHT_FULL = 4'd15;

  // BRIGHT=15 must be solidly on; a plain compare would leave one dark slot.
  function automatic logic pwm_on_f(input logic [3:0] cnt, input logic [3:0] bright);
    return (bright == BRIGHT_FULL) || (cnt < bright);
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: event hold counter, blink phase and the registered,
// polarity-corrected LED output.
module led_channel
  import led_pkg::*;
#(
  parameter int HOLD_TICKS = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TICK,
  input  logic       EVT,
  input  logic       VAL,
  input  logic [1:0] MODE,
  input  logic       pwm_on,
  output logic       LED
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);

  logic [HW-1:0] hold_q, hold_d;
  logic          phase_q, phase_d;
  logic          led_q, led_d;
  logic          level;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    hold_d  = hold_q;
    phase_d = 1'b0;
    level   = 1'b0;
    led_d   = ACTIVE_LOW;

    if (EVT) begin
      hold_d = HOLD_LOAD;
    end else if (TICK && (hold_q != '0)) begin
      hold_d = hold_q - 1'b1;
    end

    // A dropped VAL parks the phase at 0 so the next blink starts dark.
    phase_d = VAL ? (phase_q ^ TICK) : 1'b0;

    unique case (mode_e'(MODE))
      MODE_STATIC:  level = VAL;
      MODE_STRETCH: level = (hold_q != '0);
      MODE_BLINK:   level = VAL & phase_q;
      MODE_OFF:     level = 1'b0;
    endcase

    led_d = (level & pwm_on) ^ ACTIVE_LOW;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_q  <= '0;
      phase_q <= 1'b0;
      led_q   <= ACTIVE_LOW;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      hold_q  <= hold_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  assign LED = led_q;

endmodule

// File: rtl/led_driver.sv
// LED output path: shared tick prescaler and PWM counter feeding N
// hold/blink channels with registered, polarity-selectable drive.
module led_driver
  import led_pkg::*;
#(
  parameter int N          = 8,
  parameter int PRESCALE   = 1000000,
  parameter int HOLD_TICKS = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [N-1:0] VAL,
  input  logic [N-1:0] EVT,
  input  logic [1:0]   MODE,
  input  logic [3:0]   BRIGHT,
  output logic [N-1:0] LEDS,
  output logic         TICK
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [3:0]    pwm_q, pwm_d;
  logic          pwm_on;

  always_comb begin
    presc_d = (presc_q == PS_LAST) ? '0 : presc_q + 1'b1;
    tick_d  = (presc_q == PS_LAST);
    pwm_d   = pwm_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      pwm_q   <= '0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_on = pwm_on_f(pwm_q, BRIGHT);
  assign TICK   = tick_q;

  for (genvar i = 0; i < N; i++) begin : g_ch
    led_channel #(
      .HOLD_TICKS (HOLD_TICKS),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .TICK   (tick_q),
      .EVT    (EVT[i]),
      .VAL    (VAL[i]),
      .MODE   (MODE),
      .pwm_on (pwm_on),
      .LED    (LEDS[i])
    );
  end

endmodule

// File: tb/tb_led_driver.sv
// Self-checking bench for led_driver: cycle-count reference model compared
// every cycle, plus directed scenarios with hand-derived expectations.
module tb_led_driver;

  localparam int P  = 4;
  localparam int HT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] val = '0;
  logic [7:0] evt = '0;
  logic [1:0] mode = '0;
  logic [3:0] bright = '0;
  logic [7:0] leds;
  logic       tick;

  int n_pass = 0;
  int n_total = 0;

  led_driver #(
    .N          (8),
    .PRESCALE   (P),
    .HOLD_TICKS (HT),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .VAL    (val),
    .EVT    (evt),
    .MODE   (mode),
    .BRIGHT (bright),
    .LEDS   (leds),
    .TICK   (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: ticks and PWM slot follow from the number of clock
  // edges since reset release; holds and phases are plain integers.
  int         cyc;
  int         m_hold [8];
  bit         m_phase [8];
  logic [7:0] m_leds;
  bit         m_tick;

  always @(posedge clk or negedge rst_n) begin
    bit tick_old;
    bit lit_ok;
    bit lvl;
    if (!rst_n) begin
      cyc    = 0;
      m_leds = 8'hFF;
      m_tick = 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_hold[i]  = 0;
        m_phase[i] = 1'b0;
      end
    end else begin
      tick_old = (cyc > 0) && (cyc % P == 0);
      lit_ok   = (bright == 4'd15) || ((cyc % 16) < int'(bright));
      for (int i = 0; i < 8; i++) begin
        case (mode)
          2'b00:   lvl = val[i];
          2'b01:   lvl = (m_hold[i] > 0);
          2'b10:   lvl = val[i] && m_phase[i];
          default: lvl = 1'b0;
        endcase
        m_leds[i] = (lvl && lit_ok) ? 1'b0 : 1'b1;
        if (evt[i])                        m_hold[i] = HT;
        else if (tick_old && m_hold[i] > 0) m_hold[i] = m_hold[i] - 1;
        if (!val[i])       m_phase[i] = 1'b0;
        else if (tick_old) m_phase[i] = !m_phase[i];
      end
      cyc    = cyc + 1;
      m_tick = (cyc % P == 0);
    end
  end

  always @(negedge clk) begin
    check("leds_vs_model", leds, m_leds);
    check("tick_vs_model", tick, m_tick);
  end

  task automatic wait_tick();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tick !== 1'b1 && k < 50);
    if (tick !== 1'b1) check("tick_timeout", 32'(tick), 32'd1);
    #1;
  endtask

  task automatic send_evt(input logic [7:0] mask);
    evt = mask;
    @(negedge clk);
    #1 evt = '0;
  endtask

  task automatic count_lit(output int lit);
    lit = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (leds[2] == 1'b0) begin
        lit++;
        if (lit == 5) check("stretch_others_dark", leds, 8'hFB);
      end else if (lit > 0) begin
        break;
      end
    end
    #1;
  endtask

  task automatic count_low0(output int c);
    c = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (leds[0] == 1'b0) c++;
    end
    #1;
  endtask

  initial begin
    int         n;
    logic [7:0] pat;

    // Reset holds LEDS unlit whatever the inputs do.
    #1 rst_n = 1'b0;
    val = 8'h3C; evt = 8'hFF; mode = 2'b00; bright = 4'd15;
    repeat (3) @(negedge clk);
    check("reset_leds", leds, 8'hFF);
    check("reset_tick", tick, 1'b0);

    // Release: static A5 at full brightness, TICK every P cycles.
    #1;
    evt = '0; val = 8'hA5; rst_n = 1'b1;
    pat = '0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j == 0) check("static_a5", leds, 8'h5A);
      pat[j] = tick;
    end
    check("tick_pattern", pat, 8'h88);
    #1;

    // PWM duty over one full 16-slot period.
    val = 8'h01; bright = 4'd4;
    repeat (2) @(negedge clk);
    #1 count_low0(n);
    check("pwm_bright4", n, 4);
    bright = 4'd0;
    repeat (2) @(negedge clk);
    #1 count_low0(n);
    check("pwm_bright0", n, 0);
    bright = 4'd15;
    repeat (2) @(negedge clk);
    #1 count_low0(n);
    check("pwm_bright15", n, 16);

    // Stretch: mid-period event, tick collision, retrigger at hold=1.
    mode = 2'b01; val = 8'hFF;
    wait_tick();
    @(negedge clk);
    #1 send_evt(8'h04);
    count_lit(n);
    check("stretch_mid_period", n, 11);
    check("stretch_released", leds, 8'hFF);

    wait_tick();
    send_evt(8'h04);
    count_lit(n);
    check("stretch_collision", n, 12);

    wait_tick();
    @(negedge clk);
    #1 send_evt(8'h04);
    wait_tick();
    wait_tick();
    @(negedge clk);
    #1 send_evt(8'h04);
    count_lit(n);
    check("stretch_retrigger", n, 11);

    // Blink on channel 7, then drop VAL, then MODE off.
    val = 8'h00;
    wait_tick();
    @(negedge clk);
    #1;
    mode = 2'b10; val = 8'h80;
    wait_tick();
    pat = {7'b0, leds[7]};
    for (int j = 1; j < 8; j++) begin
      @(negedge clk);
      pat = {pat[6:0], leds[7]};
    end
    check("blink_pattern", pat, 8'b11000011);
    #1 val = 8'h00;
    repeat (2) @(negedge clk);
    check("blink_val_drop", leds, 8'hFF);
    #1;
    mode = 2'b11; val = 8'hFF;
    repeat (2) @(negedge clk);
    check("mode_off", leds, 8'hFF);
    #1;

    // Asynchronous reset in the middle of a hold.
    mode = 2'b01; val = 8'h00;
    wait_tick();
    @(negedge clk);
    #1 send_evt(8'h04);
    wait_tick();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_leds", leds, 8'hFF);
    @(negedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (leds[2] == 1'b0) n++;
    end
    check("hold_aborted", n, 0);
    #1;

    // Randomized traffic, checked against the model every cycle.
    for (int c = 0; c < 1500; c++) begin
      if (c % 50 == 0) mode = 2'($urandom());
      if (c % 20 == 0) bright = 4'($urandom());
      if (c % 30 == 0) val = 8'($urandom());
      evt = 8'($urandom() & $urandom() & $urandom() & $urandom());
      @(negedge clk);
      #1;
    end
    evt = '0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
